inst_buffer: RTL
================

Name: inst_buffer

Overview:
Instruction buffer at the far end of the predecode→ibuffer interface. Each cycle it accepts one compacted fetch packet of up to BLOCK_INST_SIZE instructions from the predecode stage and presents up to DECODE_WIDTH in-order instructions to decode. It also drives the back-pressure signal `full`, which predecode samples as ibuf_full. It is flushed on frontend redirect.

Parameters:
BLOCK_INST_SIZE, 8, max instructions per incoming packet
DECODE_WIDTH, 4, instructions presented to decode per cycle
DEPTH, 32, entries; power of two, >= 2*BLOCK_INST_SIZE
FSQ_WIDTH, 4, fetch-stream-queue index width
OFFSET_WIDTH, 4, instruction offset-in-block width

Ports:
clk  in  1  clock
rst  in  1  reset
flush  in  1  frontend redirect; discard all contents
in_en  in  BLOCK_INST_SIZE  per-lane valid, prefix mask (lane0..num-1)
in_num  in  $clog2(BLOCK_INST_SIZE)+1  count of valid lanes
in_inst  in  BLOCK_INST_SIZE*32  instruction words, lane-packed
in_offset  in  BLOCK_INST_SIZE*OFFSET_WIDTH  per-lane offset in fetch block
in_fsq_idx  in  FSQ_WIDTH  stream index, shared by packet
in_ipf  in  BLOCK_INST_SIZE  per-lane instruction page fault
in_iam  in  1  packet misaligned
full  out  1  cannot accept a full packet this cycle
out_valid  out  DECODE_WIDTH  prefix mask of valid output lanes
out_inst  out  DECODE_WIDTH*32  instructions, oldest in lane 0
out_offset  out  DECODE_WIDTH*OFFSET_WIDTH  offsets
out_fsq_idx  out  DECODE_WIDTH*FSQ_WIDTH  per-lane stream index
out_exc  out  DECODE_WIDTH*2  per-lane {iam, ipf}
out_ready  in  1  decode accepts every asserted out_valid lane this cycle

Behaviour:
- Reset (async, active-high, rst; clock clk): head=tail=0, count=0; out_valid=0; full=0. Entry storage is not reset.
- Storage: circular array of DEPTH entries {inst, offset, fsq_idx, iam, ipf}. Head and tail are $clog2(DEPTH) bits and wrap modulo DEPTH. count is $clog2(DEPTH)+1 bits.
- full = (DEPTH - count) < BLOCK_INST_SIZE. Combinational from registered count only; same-cycle reads are ignored (conservative).
- Write condition: in_en[0] & ~full & ~flush. Lane i (i<in_num) goes to entry (tail+i) mod DEPTH. tail += in_num.
- If in_en[0] is high while full=1, the packet is ignored. Predecode holds it; this is not an error.
- Output: lane j valid iff j < count. Lane j reads entry (head+j) mod DEPTH. Write-to-output latency is 1 cycle (no bypass).
- Pop: pop = out_ready ? min(count, DECODE_WIDTH) : 0. head += pop.
- Next count = count + write_num - pop. Simultaneous write and pop are both applied.
- Flush has priority over write and pop. Next cycle: head=tail=count=0 and out_valid=0. A packet presented in the flush cycle is dropped.
- Wrap-around: a packet may straddle entry DEPTH-1 → 0. Output lanes may straddle likewise.
- Invariant: count never exceeds DEPTH. Assert (simulation only) that in_num equals popcount(in_en) and that in_en is a prefix mask.

Optional Feature:
IBUF_BYPASS_EN
- Defined: when count==0, out_ready=1 and a write occurs, lanes 0..min(in_num,DECODE_WIDTH)-1 are presented on the outputs combinationally in the same cycle and counted as popped. Only the remaining in_num-DECODE_WIDTH lanes are written, at tail. head/tail advance by in_num total. With out_ready=0 or count>0, behaviour equals the undefined case.
- Undefined: strict 1-cycle latency as above.

Test Plan:
- Reset then idle → out_valid=0, full=0, count=0 for 10 cycles.
- Write 8 instructions (0x100..0x107, fsq_idx=3) with out_ready=0 → next cycle out_valid=4'b1111, out_inst lane0=0x100, lane3=0x103; count=8.
- With the buffer at count=25 → full=1; presented packet ignored; pop 4 → count=21, full=0 next cycle; next packet accepted.
- Fill to tail=28, write 8 lanes → entries 28..31 and 0..3 written; drain in order 0x..lane0 to lane7 across the wrap with no gap.
- flush asserted together with a write of 5 and out_ready=1 at count=12 → next cycle count=0, out_valid=0, no pop observed beyond the flush cycle, packet dropped.
- IBUF_BYPASS_EN, empty buffer, out_ready=1, write 6 → same-cycle out_valid=4'b1111 (lanes 0..3); next cycle out_valid=4'b0011 with lanes 4,5; ipf lane5=1 → out_exc lane1=2'b01.

Source files
------------

// File: rtl/inst_buffer.sv
// Instruction buffer: accepts one fetch packet per cycle, presents up to DECODE_WIDTH in-order lanes to decode.
// Latency: 1 cycle write-to-output (0 for the empty-buffer fast path when IBUF_BYPASS_EN is defined).
// Backpressure: full asserts whenever a maximum-size packet might not fit; packets seen while full are dropped.
module inst_buffer #(
  parameter int BLOCK_INST_SIZE = 8,
  parameter int DECODE_WIDTH    = 4,
  parameter int DEPTH           = 32,
  parameter int FSQ_WIDTH       = 4,
  parameter int OFFSET_WIDTH    = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 flush,
  input  logic [BLOCK_INST_SIZE-1:0]           in_en,
  input  logic [$clog2(BLOCK_INST_SIZE):0]     in_num,
  input  logic [BLOCK_INST_SIZE*32-1:0]        in_inst,
  input  logic [BLOCK_INST_SIZE*OFFSET_WIDTH-1:0] in_offset,
  input  logic [FSQ_WIDTH-1:0]                 in_fsq_idx,
  input  logic [BLOCK_INST_SIZE-1:0]           in_ipf,
  input  logic                                 in_iam,
  output logic                                 full,
  output logic [DECODE_WIDTH-1:0]              out_valid,
  output logic [DECODE_WIDTH*32-1:0]           out_inst,
  output logic [DECODE_WIDTH*OFFSET_WIDTH-1:0] out_offset,
  output logic [DECODE_WIDTH*FSQ_WIDTH-1:0]    out_fsq_idx,
  output logic [DECODE_WIDTH*2-1:0]            out_exc,
  input  logic                                 out_ready
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;
  localparam int NUM_W  = $clog2(BLOCK_INST_SIZE) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] BLOCK_C = CNT_W'(BLOCK_INST_SIZE);
  localparam logic [CNT_W-1:0] DW_C    = CNT_W'(DECODE_WIDTH);
  localparam logic [BLOCK_INST_SIZE-1:0] ONE_B = BLOCK_INST_SIZE'(1);

  typedef struct packed {
    logic [31:0]             inst;
    logic [OFFSET_WIDTH-1:0] offset;
    logic [FSQ_WIDTH-1:0]    fsq_idx;
    logic                    iam;
    logic                    ipf;
  } entry_t;

  entry_t            mem [DEPTH];
  entry_t            in_ent [BLOCK_INST_SIZE];
  entry_t            lane_ent;
  logic [ADDR_W-1:0] head;
  logic [ADDR_W-1:0] tail;
  logic [CNT_W-1:0]  count;

  logic [CNT_W-1:0]  free_cnt;
  logic [CNT_W-1:0]  in_num_w;
  logic [CNT_W-1:0]  wr_num;
  logic [CNT_W-1:0]  pop_num;
  logic [CNT_W-1:0]  byp_num;
  logic              wr_en;
  logic              byp_en;

  // Conservative: a pop in the same cycle never frees space for the incoming packet.
  assign free_cnt = DEPTH_C - count;
  assign full     = free_cnt < BLOCK_C;
  assign wr_en    = in_en[0] & ~full & ~flush;
  assign in_num_w = CNT_W'(in_num);
  assign wr_num   = wr_en ? in_num_w : '0;

`ifdef IBUF_BYPASS_EN
  assign byp_en = wr_en & out_ready & (count == '0);
`else
  assign byp_en = 1'b0;
`endif

  always_comb begin
    byp_num = '0;
    if (byp_en) begin
      byp_num = (in_num_w < DW_C) ? in_num_w : DW_C;
    end
  end

  always_comb begin
    pop_num = '0;
    if (byp_en) begin
      pop_num = byp_num;
    end else if (out_ready) begin
      pop_num = (count < DW_C) ? count : DW_C;
    end
  end

  always_comb begin
    for (int i = 0; i < BLOCK_INST_SIZE; i++) begin
      in_ent[i].inst    = in_inst[i*32 +: 32];
      in_ent[i].offset  = in_offset[i*OFFSET_WIDTH +: OFFSET_WIDTH];
      in_ent[i].fsq_idx = in_fsq_idx;
      in_ent[i].iam     = in_iam;
      in_ent[i].ipf     = in_ipf[i];
    end
  end

  // Lane i always lands at tail+i; lanes consumed by the bypass path are skipped.
  always_ff @(posedge clk) begin
    for (int i = 0; i < BLOCK_INST_SIZE; i++) begin
      if (wr_en && (NUM_W'(i) < in_num) && (CNT_W'(i) >= byp_num)) begin
        mem[tail + ADDR_W'(i)] <= in_ent[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + pop_num[ADDR_W-1:0];
      tail  <= tail + wr_num[ADDR_W-1:0];
      count <= count + wr_num - pop_num;
    end
  end

  always_comb begin
    out_valid   = '0;
    out_inst    = '0;
    out_offset  = '0;
    out_fsq_idx = '0;
    out_exc     = '0;
    lane_ent    = '0;
    for (int j = 0; j < DECODE_WIDTH; j++) begin
      if (byp_en) begin
        lane_ent     = in_ent[j];
        out_valid[j] = CNT_W'(j) < byp_num;
      end else begin
        lane_ent     = mem[head + ADDR_W'(j)];
        out_valid[j] = CNT_W'(j) < count;
      end
      out_inst[j*32 +: 32]                     = lane_ent.inst;
      out_offset[j*OFFSET_WIDTH +: OFFSET_WIDTH] = lane_ent.offset;
      out_fsq_idx[j*FSQ_WIDTH +: FSQ_WIDTH]    = lane_ent.fsq_idx;
      out_exc[j*2 +: 2]                        = {lane_ent.iam, lane_ent.ipf};
    end
  end

  // Predecode must deliver a compacted packet: prefix mask whose popcount is in_num.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ($countones(in_en) == int'(in_num));
      assert ((in_en & (in_en + ONE_B)) == '0);
      assert (count <= DEPTH_C);
    end
  end

endmodule
